// File: rtl/c1541_pkg.sv
// Shared types and helpers for the 1541 track-buffer controller.
package c1541_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FLUSH_REQ,
    FLUSH_WAIT,
    LOAD_REQ,
    LOAD_WAIT,
    READY
  } trk_state_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_REQ,
    XF_WAIT
  } xfer_state_t;

  localparam int unsigned SD_BLK_BYTES = 512;

  // Image layout is a flat array of half-tracks, each a fixed run of SD blocks.
  function automatic logic [31:0] trk_lba(input logic [31:0] base,
                                          input logic [6:0]  track,
                                          input logic [3:0]  blk,
                                          input int unsigned blocks);
    return base + 32'(track) * blocks + 32'(blk);
  endfunction

endpackage

// File: rtl/c1541_sd_xfer.sv
// Single SD block handshake: raise rd/wr, drop it on the first ack, then
// report done once the SD side releases ack.
module c1541_sd_xfer
  import c1541_pkg::*;
(
  input  logic        clk32,
  input  logic        reset,
  input  logic        start,
  input  logic        wr,
  input  logic [31:0] lba,
  input  logic        ack,
  output logic        done,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_lba
);

  xfer_state_t state_reg;

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_reg <= XF_IDLE;
      done      <= 1'b0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      sd_lba    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        XF_IDLE: begin
          if (start) begin
            sd_lba    <= lba;
            sd_rd     <= !wr;
            sd_wr     <= wr;
            state_reg <= XF_REQ;
          end
        end
        XF_REQ: begin
          if (ack) begin
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            state_reg <= XF_WAIT;
          end
        end
        XF_WAIT: begin
          if (!ack) begin
            done      <= 1'b1;
            state_reg <= XF_IDLE;
          end
        end
        default: state_reg <= XF_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/c1541_track_ctrl.sv
// Track-buffer sequencer: settle after head moves, optionally write back a dirty
// track, then load the new one block by block. Write-back needs C1541_DIRTY_FLUSH_EN.
module c1541_track_ctrl
  import c1541_pkg::*;
#(
  parameter int unsigned BLOCKS_PER_TRACK = 16,
  parameter int unsigned SETTLE_CYCLES    = 640000,
  parameter logic [31:0] BASE_LBA         = 32'd0
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic [6:0]  half_track,
  input  logic        mtr,
  input  logic        img_mounted,
  input  logic        gcr_we,
  output logic        ram_ready,
  output logic [6:0]  cur_track,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [3:0]  sd_blk
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_BLK = 4'(BLOCKS_PER_TRACK - 1);

  trk_state_t       state_reg;
  logic [CNT_W-1:0] settle_cnt_reg;
  logic [6:0]       tgt_track_reg;
  logic [6:0]       cur_track_reg;
  logic [3:0]       blk_reg;
  logic             dirty_reg, valid_reg, ram_ready_reg, abort_reg, flush_only_reg;
`ifdef C1541_DIRTY_FLUSH_EN
  logic             mtr_reg;
`endif

  logic        is_flush, in_xfer, xfer_start, xfer_done, xfer_rd, xfer_wr, xfer_acked;
  logic [6:0]  req_track;
  logic [31:0] req_lba;

  assign is_flush   = (state_reg == FLUSH_REQ) || (state_reg == FLUSH_WAIT);
  assign in_xfer    = is_flush || (state_reg == LOAD_REQ) || (state_reg == LOAD_WAIT);
  assign xfer_start = (state_reg == FLUSH_REQ) || (state_reg == LOAD_REQ);
  assign req_track  = is_flush ? cur_track_reg : tgt_track_reg;
  assign req_lba    = trk_lba(BASE_LBA, req_track, blk_reg, BLOCKS_PER_TRACK);
  assign xfer_acked = sd_ack && (xfer_rd || xfer_wr);

  c1541_sd_xfer u_xfer (
    .clk32  (clk32),
    .reset  (reset),
    .start  (xfer_start),
    .wr     (is_flush),
    .lba    (req_lba),
    .ack    (sd_ack),
    .done   (xfer_done),
    .sd_rd  (xfer_rd),
    .sd_wr  (xfer_wr),
    .sd_lba (sd_lba)
  );

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      tgt_track_reg  <= 7'd0;
      cur_track_reg  <= 7'd0;
      blk_reg        <= 4'd0;
      dirty_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      ram_ready_reg  <= 1'b0;
      abort_reg      <= 1'b0;
      flush_only_reg <= 1'b0;
`ifdef C1541_DIRTY_FLUSH_EN
      mtr_reg        <= 1'b0;
`endif
    end else begin
`ifdef C1541_DIRTY_FLUSH_EN
      mtr_reg <= mtr;
`endif
      case (state_reg)
        IDLE: begin
          ram_ready_reg <= 1'b0;
          abort_reg     <= 1'b0;
          if (!valid_reg || half_track != cur_track_reg) begin
            tgt_track_reg  <= half_track;
            settle_cnt_reg <= '0;
            state_reg      <= SETTLE;
          end
        end
        SETTLE: begin
          ram_ready_reg <= 1'b0;
          if (half_track != tgt_track_reg) begin
            tgt_track_reg  <= half_track;
            settle_cnt_reg <= '0;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            blk_reg   <= 4'd0;
            state_reg <= (dirty_reg && valid_reg) ? FLUSH_REQ : LOAD_REQ;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        FLUSH_REQ: if (xfer_acked) state_reg <= FLUSH_WAIT;
        FLUSH_WAIT: begin
          if (xfer_done) begin
            if (abort_reg) begin
              state_reg <= IDLE;
            end else if (blk_reg == LAST_BLK) begin
              dirty_reg      <= 1'b0;
              blk_reg        <= 4'd0;
              flush_only_reg <= 1'b0;
              state_reg      <= flush_only_reg ? READY : LOAD_REQ;
            end else begin
              blk_reg   <= blk_reg + 4'd1;
              state_reg <= FLUSH_REQ;
            end
          end
        end
        LOAD_REQ: if (xfer_acked) state_reg <= LOAD_WAIT;
        LOAD_WAIT: begin
          if (xfer_done) begin
            if (abort_reg) begin
              state_reg <= IDLE;
            end else if (blk_reg == LAST_BLK) begin
              cur_track_reg <= tgt_track_reg;
              valid_reg     <= 1'b1;
              state_reg     <= READY;
            end else begin
              blk_reg   <= blk_reg + 4'd1;
              state_reg <= LOAD_REQ;
            end
          end
        end
        READY: begin
          if (half_track != cur_track_reg) begin
            ram_ready_reg  <= 1'b0;
            tgt_track_reg  <= half_track;
            settle_cnt_reg <= '0;
            state_reg      <= SETTLE;
          end
`ifdef C1541_DIRTY_FLUSH_EN
          else if (mtr_reg && !mtr && dirty_reg) begin
            ram_ready_reg  <= 1'b0;
            blk_reg        <= 4'd0;
            flush_only_reg <= 1'b1;
            state_reg      <= FLUSH_REQ;
          end
`endif
          else begin
            ram_ready_reg <= 1'b1;
`ifdef C1541_DIRTY_FLUSH_EN
            if (gcr_we) dirty_reg <= 1'b1;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A new image invalidates the buffer; an in-flight block is allowed to finish.
      if (img_mounted) begin
        dirty_reg <= 1'b0;
        valid_reg <= 1'b0;
        if (in_xfer) begin
          abort_reg <= 1'b1;
        end else begin
          ram_ready_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      end
    end
  end

  // Drop ready in the same cycle the head leaves the buffered track.
  assign ram_ready = ram_ready_reg && (half_track == cur_track_reg);
  assign cur_track = cur_track_reg;
  assign sd_blk    = blk_reg;
  assign sd_rd     = xfer_rd;

`ifdef C1541_DIRTY_FLUSH_EN
  assign sd_wr = xfer_wr;
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, gcr_we, mtr, xfer_wr};
  assign sd_wr = 1'b0;
`endif

endmodule
